coeff_load_ctrl: RTL and testbench

COEFF_LOAD_CTRL -- requirements
Module: coeff_load_ctrl

---
 rtl/coeff_load_ctrl.sv | 175 +++++++++++++++++
 tb/tb_coeff_load_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_load_ctrl.sv
// Loads NUM_COEFF coefficients from BRAM into the coefficient bank and commits the set on the next vsync rise.
// Each coefficient takes FETCH, RD_LAT wait cycles, then XFER; XFER holds until both channels have handshaken.

module coeff_load_ctrl #(
  parameter int NUM_COEFF = 25,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reload_i,
  input  logic [31:0] base_addr_i,
  input  logic        vs_i,
  output logic        bram_en,
  output logic [31:0] bram_addr,
  input  logic [31:0] bram_dout,
  output logic [31:0] filter_addr,
  output logic        filter_addr_valid,
  input  logic        filter_addr_ready,
  output logic [31:0] filter_data,
  output logic        filter_data_valid,
  input  logic        filter_data_ready,
  output logic        commit_o,
  output logic        busy_o
);

  localparam int                IDX_W    = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_COEFF - 1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    XFER,
    ARMED,
    COMMIT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      hold_q, hold_d;
  logic             pending_q, pending_d;
  logic             vs_q, vs_d;
  logic [1:0]       lat_cnt_q, lat_cnt_d;
  logic             addr_done_q, addr_done_d;
  logic             data_done_q, data_done_d;

  logic vs_rise;
  logic addr_hs;
  logic data_hs;
  logic addr_done_now;
  logic data_done_now;

  assign vs_rise = vs_i & ~vs_q;

  // Each channel's valid drops once its own handshake is recorded, independent of the other.
  assign filter_addr_valid = (state_q == XFER) && !addr_done_q;
  assign filter_data_valid = (state_q == XFER) && !data_done_q;
  assign filter_addr       = 32'(idx_q);
  assign filter_data       = hold_q;

  assign addr_hs       = filter_addr_valid & filter_addr_ready;
  assign data_hs       = filter_data_valid & filter_data_ready;
  assign addr_done_now = addr_done_q | addr_hs;
  assign data_done_now = data_done_q | data_hs;

  assign bram_en   = (state_q == FETCH);
  assign bram_addr = base_q + 32'(idx_q);
  assign commit_o  = (state_q == COMMIT);
  assign busy_o    = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    hold_d      = hold_q;
    pending_d   = pending_q;
    vs_d        = vs_i;
    lat_cnt_d   = lat_cnt_q;
    addr_done_d = addr_done_q;
    data_done_d = data_done_q;

    unique case (state_q)
      IDLE: begin
        if (reload_i || pending_q) begin
          state_d   = FETCH;
          base_d    = base_addr_i;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end

      FETCH: begin
        if (reload_i) pending_d = 1'b1;
        lat_cnt_d = 2'd0;
        state_d   = WAIT;
      end

      WAIT: begin
        if (reload_i) pending_d = 1'b1;
        if (lat_cnt_q == LAT_LAST) begin
          hold_d      = bram_dout;
          addr_done_d = 1'b0;
          data_done_d = 1'b0;
          state_d     = XFER;
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end

      XFER: begin
        if (reload_i) pending_d = 1'b1;
        if (addr_done_now && data_done_now) begin
          addr_done_d = 1'b0;
          data_done_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ARMED;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = FETCH;
          end
        end else begin
          addr_done_d = addr_done_now;
          data_done_d = data_done_now;
        end
      end

      ARMED: begin
        // A vsync edge takes priority; a simultaneous reload is deferred through pending.
        if (vs_rise) begin
          state_d = COMMIT;
          if (reload_i) pending_d = 1'b1;
        end else if (reload_i) begin
          state_d   = FETCH;
          base_d    = base_addr_i;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end

      COMMIT: begin
        if (reload_i) pending_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      hold_q      <= '0;
      pending_q   <= 1'b0;
      vs_q        <= 1'b0;
      lat_cnt_q   <= 2'd0;
      addr_done_q <= 1'b0;
      data_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      hold_q      <= hold_d;
      pending_q   <= pending_d;
      vs_q        <= vs_d;
      lat_cnt_q   <= lat_cnt_d;
      addr_done_q <= addr_done_d;
      data_done_q <= data_done_d;
    end
  end

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Directed bench for coeff_load_ctrl: a cycle table for the start of a load, then hand-written corner sequences.
// BRAM word at address a holds a - 246, so base 0x100 yields coefficient k = k + 10.

module tb_coeff_load_ctrl;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // DUT 1: RD_LAT = 1
  logic        reload1, vs1, en1, avld1, ardy1, dvld1, drdy1, commit1, busy1;
  logic [31:0] base1, baddr1, dout1, faddr1, fdata1;
  // DUT 2: RD_LAT = 3
  logic        reload2, vs2, en2, avld2, ardy2, dvld2, drdy2, commit2, busy2;
  logic [31:0] base2, baddr2, dout2, faddr2, fdata2;
  logic [31:0] p2a, p2b;

  coeff_load_ctrl #(.NUM_COEFF(25), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .reload_i(reload1), .base_addr_i(base1), .vs_i(vs1),
    .bram_en(en1), .bram_addr(baddr1), .bram_dout(dout1),
    .filter_addr(faddr1), .filter_addr_valid(avld1), .filter_addr_ready(ardy1),
    .filter_data(fdata1), .filter_data_valid(dvld1), .filter_data_ready(drdy1),
    .commit_o(commit1), .busy_o(busy1)
  );

  coeff_load_ctrl #(.NUM_COEFF(25), .RD_LAT(3)) dut2 (
    .clk(clk), .rst(rst), .reload_i(reload2), .base_addr_i(base2), .vs_i(vs2),
    .bram_en(en2), .bram_addr(baddr2), .bram_dout(dout2),
    .filter_addr(faddr2), .filter_addr_valid(avld2), .filter_addr_ready(ardy2),
    .filter_data(fdata2), .filter_data_valid(dvld2), .filter_data_ready(drdy2),
    .commit_o(commit2), .busy_o(busy2)
  );

  // BRAM models; non-read cycles load a poison word so mistimed captures show up.
  always @(posedge clk) dout1 <= en1 ? baddr1 - 32'd246 : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    p2a   <= en2 ? baddr2 - 32'd246 : 32'hDEAD_BEEF;
    p2b   <= p2a;
    dout2 <= p2b;
  end

  int          en_c1[$], dh_c1[$], cm1[$];
  logic [31:0] ah1[$], dh1[$];
  int          en_c2[$], xf_c2[$];
  logic [31:0] dh2[$];
  logic        avld2_prev = 1'b0;

  always @(negedge clk) begin
    if (en1) en_c1.push_back(cyc);
    if (avld1 && ardy1) ah1.push_back(faddr1);
    if (dvld1 && drdy1) begin
      dh1.push_back(fdata1);
      dh_c1.push_back(cyc);
    end
    if (commit1) cm1.push_back(cyc);
    if (en2) en_c2.push_back(cyc);
    if (avld2 && !avld2_prev) xf_c2.push_back(cyc);
    avld2_prev = avld2;
    if (dvld2 && drdy2) dh2.push_back(fdata2);
  end

  typedef struct {
    logic        reload, ardy, drdy;
    logic        en;
    logic [31:0] baddr;
    logic        avld;
    logic [31:0] faddr;
    logic        dvld;
    logic [31:0] fdata;
    logic        busy;
  } vec_t;

  vec_t tbl[9];
  int   F, V, R;

  function automatic vec_t mk(input bit rl, ar, dr, en, input logic [31:0] ba, input bit av,
                              input logic [31:0] fa, input bit dv, input logic [31:0] fd, input bit bz);
    vec_t v;
    v.reload = rl; v.ardy = ar; v.drdy = dr; v.en = en; v.baddr = ba;
    v.avld = av; v.faddr = fa; v.dvld = dv; v.fdata = fd; v.busy = bz;
    return v;
  endfunction

  task automatic chk1(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk32(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chki(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear1();
    en_c1.delete(); dh_c1.delete(); cm1.delete(); ah1.delete(); dh1.delete();
  endtask

  task automatic chk_load1(input string n, input logic [31:0] base);
    chki({n, " xfer count"}, dh1.size(), 25);
    for (int k = 0; k < dh1.size() && k < ah1.size(); k++) begin
      chk32($sformatf("%s addr k=%0d", n, k), ah1[k], 32'(k));
      chk32($sformatf("%s data k=%0d", n, k), dh1[k], base + 32'(k) - 32'd246);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    reload1 = 1'b0; base1 = '0; vs1 = 1'b0; ardy1 = 1'b1; drdy1 = 1'b1;
    reload2 = 1'b0; base2 = '0; vs2 = 1'b0; ardy2 = 1'b1; drdy2 = 1'b1;

    tbl[0] = mk(H, H, H, L, 32'h0,   L, 32'h0, L, 32'h0,  L);
    tbl[1] = mk(L, H, H, H, 32'h100, L, 32'h0, L, 32'h0,  H);
    tbl[2] = mk(L, H, H, L, 32'h0,   L, 32'h0, L, 32'h0,  H);
    tbl[3] = mk(L, H, H, L, 32'h0,   H, 32'd0, H, 32'd10, H);
    tbl[4] = mk(L, H, H, H, 32'h101, L, 32'h0, L, 32'h0,  H);
    tbl[5] = mk(L, H, H, L, 32'h0,   L, 32'h0, L, 32'h0,  H);
    tbl[6] = mk(L, H, L, L, 32'h0,   H, 32'd1, H, 32'd11, H);
    tbl[7] = mk(L, H, H, L, 32'h0,   L, 32'h0, H, 32'd11, H);
    tbl[8] = mk(L, H, H, H, 32'h102, L, 32'h0, L, 32'h0,  H);

    // Reset state
    #12;
    chk1("rst bram_en", en1, 1'b0);
    chk32("rst bram_addr", baddr1, 32'h0);
    chk1("rst addr_valid", avld1, 1'b0);
    chk1("rst data_valid", dvld1, 1'b0);
    chk32("rst filter_addr", faddr1, 32'h0);
    chk32("rst filter_data", fdata1, 32'h0);
    chk1("rst commit", commit1, 1'b0);
    chk1("rst busy", busy1, 1'b0);
    chk1("rst busy2", busy2, 1'b0);
    tick(); rst = 1'b1; tick(); tick();

    // Table: start of a load with a one-cycle data stall on k=1
    base1 = 32'h100;
    clear1();
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 1) F = cyc;
      reload1 = tbl[i].reload; ardy1 = tbl[i].ardy; drdy1 = tbl[i].drdy;
      chk1($sformatf("tbl%0d bram_en", i), en1, tbl[i].en);
      if (tbl[i].en) chk32($sformatf("tbl%0d bram_addr", i), baddr1, tbl[i].baddr);
      chk1($sformatf("tbl%0d addr_valid", i), avld1, tbl[i].avld);
      if (tbl[i].avld) chk32($sformatf("tbl%0d filter_addr", i), faddr1, tbl[i].faddr);
      chk1($sformatf("tbl%0d data_valid", i), dvld1, tbl[i].dvld);
      if (tbl[i].dvld) chk32($sformatf("tbl%0d filter_data", i), fdata1, tbl[i].fdata);
      chk1($sformatf("tbl%0d busy", i), busy1, tbl[i].busy);
    end
    for (int t = 0; t < 300 && dh1.size() < 25; t++) tick();
    chk_load1("basic", 32'h100);
    chki("basic last xfer cycle", (dh_c1.size() > 0) ? dh_c1[$] : -1, F + 75);
    tick(); tick();
    chk1("armed busy", busy1, 1'b1);
    chki("armed no commit", cm1.size(), 0);
    vs1 = 1'b1; V = cyc;
    tick();
    chk1("commit pulse", commit1, 1'b1);
    tick();
    chk1("commit one cycle", commit1, 1'b0);
    chk1("idle after commit", busy1, 1'b0);
    tick();
    chk1("stays idle", busy1, 1'b0);
    vs1 = 1'b0;
    chki("basic commit count", cm1.size(), 1);
    chki("basic commit cycle", (cm1.size() > 0) ? cm1[0] : -1, V + 1);

    // Clean load timing, reload while busy, vs during XFER k=10
    tick();
    clear1();
    reload1 = 1'b1; F = cyc + 1;
    tick(); reload1 = 1'b0;
    until_cyc(F + 17); reload1 = 1'b1;
    tick(); reload1 = 1'b0;
    until_cyc(F + 32);
    chk1("xfer10 addr_valid", avld1, 1'b1);
    chk32("xfer10 filter_addr", faddr1, 32'd10);
    vs1 = 1'b1;
    tick(); vs1 = 1'b0;
    until_cyc(F + 75);
    chk1("timing armed busy", busy1, 1'b1);
    chki("timing fetch count", en_c1.size(), 25);
    chki("timing last xfer", (dh_c1.size() > 0) ? dh_c1[$] : -1, F + 74);
    chki("vs in xfer no commit", cm1.size(), 0);
    chk_load1("timing", 32'h100);
    until_cyc(F + 78);
    vs1 = 1'b1; V = cyc;
    tick();
    chk1("pending commit", commit1, 1'b1);
    tick();
    chk1("pending idle 1 cycle", busy1, 1'b0);
    tick();
    chk1("pending fetch", en1, 1'b1);
    chk32("pending fetch addr", baddr1, 32'h100);
    chki("pending commit count", cm1.size(), 1);
    F = cyc;

    // Backpressure on data at k=3 with address ready
    clear1();
    vs1 = 1'b0;
    until_cyc(F + 11);
    drdy1 = 1'b0;
    chk1("bp k3 addr_valid", avld1, 1'b1);
    chk32("bp k3 filter_addr", faddr1, 32'd3);
    chk32("bp k3 filter_data", fdata1, 32'd13);
    for (int j = 1; j < 5; j++) begin
      tick();
      chk1($sformatf("bp stall%0d addr_valid", j), avld1, 1'b0);
      chk1($sformatf("bp stall%0d data_valid", j), dvld1, 1'b1);
      chk32($sformatf("bp stall%0d filter_data", j), fdata1, 32'd13);
      chk1($sformatf("bp stall%0d bram_en", j), en1, 1'b0);
    end
    tick(); drdy1 = 1'b1;
    chk1("bp release data_valid", dvld1, 1'b1);
    chk32("bp release filter_data", fdata1, 32'd13);
    tick();
    chk1("bp next fetch", en1, 1'b1);
    chk32("bp next fetch addr", baddr1, 32'h104);
    until_cyc(F + 82);
    chk1("bp armed busy", busy1, 1'b1);
    chk_load1("bp", 32'h100);
    chki("bp no commit", cm1.size(), 0);

    // Reload in ARMED without vs discards the set and restarts at the new base
    reload1 = 1'b1; base1 = 32'h200;
    clear1();
    tick(); reload1 = 1'b0;
    chk1("restart fetch", en1, 1'b1);
    chk32("restart fetch addr", baddr1, 32'h200);
    F = cyc;
    until_cyc(F + 77);
    chk_load1("restart", 32'h200);
    chki("restart no commit", cm1.size(), 0);

    // vs and reload in the same ARMED cycle
    vs1 = 1'b1; reload1 = 1'b1; base1 = 32'h300;
    tick(); reload1 = 1'b0;
    chk1("vs+reload commit", commit1, 1'b1);
    tick();
    chk1("vs+reload idle", busy1, 1'b0);
    chk1("vs+reload idle no fetch", en1, 1'b0);
    tick();
    chk1("vs+reload fetch", en1, 1'b1);
    chk32("vs+reload fetch addr", baddr1, 32'h300);
    F = cyc;
    vs1 = 1'b0;

    // Reset mid-load at k=12
    until_cyc(F + 38);
    chk1("pre-reset addr_valid", avld1, 1'b1);
    chk32("pre-reset filter_addr", faddr1, 32'd12);
    chk32("pre-reset filter_data", fdata1, 32'h300 + 32'd12 - 32'd246);
    clear1();
    rst = 1'b0;
    #1;
    chk1("mid rst bram_en", en1, 1'b0);
    chk32("mid rst bram_addr", baddr1, 32'h0);
    chk1("mid rst addr_valid", avld1, 1'b0);
    chk1("mid rst data_valid", dvld1, 1'b0);
    chk32("mid rst filter_addr", faddr1, 32'h0);
    chk32("mid rst filter_data", fdata1, 32'h0);
    chk1("mid rst busy", busy1, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j == 3) vs1 = 1'b1;
    end
    vs1 = 1'b0;
    chk1("post rst idle", busy1, 1'b0);
    chki("post rst no fetch", en_c1.size(), 0);
    chki("post rst no commit", cm1.size(), 0);

    // RD_LAT = 3 instance
    tick();
    base2 = 32'h100; reload2 = 1'b1;
    en_c2.delete(); xf_c2.delete(); dh2.delete();
    tick(); reload2 = 1'b0;
    for (int t = 0; t < 400 && dh2.size() < 25; t++) tick();
    chki("lat3 fetch count", en_c2.size(), 25);
    chki("lat3 xfer count", xf_c2.size(), 25);
    chki("lat3 data count", dh2.size(), 25);
    for (int k = 0; k < 25 && k < en_c2.size() && k < xf_c2.size() && k < dh2.size(); k++) begin
      chki($sformatf("lat3 spacing k=%0d", k), xf_c2[k] - en_c2[k], 4);
      chk32($sformatf("lat3 data k=%0d", k), dh2[k], 32'(k) + 32'd10);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
